// File: rtl/alu_console.sv
// Operator console: assembles multi-chunk operands for an external ALU and keeps a DEPTH-entry result history.
// Optional edge-detected, synchronised strobe with `define ALU_CONSOLE_EDGE_EN (default: level strobe).
module alu_console #(
    parameter int WIDTH = 32,
    parameter int IN_W  = 5,
    parameter int OP_W  = 5,
    parameter int DEPTH = 8,
    localparam int VW   = $clog2(DEPTH),
    localparam int CW   = VW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [IN_W-1:0]  in,
    input  logic [2:0]       ctrl,
    input  logic [WIDTH-1:0] alu_res,
    output logic [WIDTH-1:0] alu_src0,
    output logic [WIDTH-1:0] alu_src1,
    output logic [OP_W-1:0]  alu_op,
    output logic [WIDTH-1:0] data_out,
    output logic [CW-1:0]    hist_count,
    output logic [VW-1:0]    view_idx
);

    typedef enum logic [2:0] {
        LOAD_OP = 3'b000,
        LOAD_A  = 3'b001,
        LOAD_B  = 3'b010,
        EXEC    = 3'b011,
        OLDER   = 3'b100,
        NEWER   = 3'b101,
        CLEAR   = 3'b110,
        NOP     = 3'b111
    } act_e;

    logic strobe;

`ifdef ALU_CONSOLE_EDGE_EN
    // bit0 = s1, bit1 = s2 (synchronised), bit2 = s3 (previous s2)
    logic [2:0] vld_pipe;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[1:0], enable};
    end
    assign strobe = vld_pipe[1] & ~vld_pipe[2];
`else
    assign strobe = enable;
`endif

    // Shift by IN_W is written as a shift so IN_W == WIDTH degenerates to a plain replace.
    function automatic logic [WIDTH-1:0] chunk(input logic [WIDTH-1:0] cur, input logic fresh,
                                               input logic [IN_W-1:0] d);
        logic [WIDTH-1:0] sh;
        sh = cur << IN_W;
        if (fresh) return WIDTH'($signed(d));
        return sh | WIDTH'(d);
    endfunction

    logic                         fresh0, fresh1;
    logic [VW-1:0]                wp;
    logic [DEPTH-1:0][WIDTH-1:0]  hist;
    logic [VW-1:0]                rd_idx;
    act_e                         act;

    assign act = act_e'(ctrl);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_src0   <= '0;
            alu_src1   <= '0;
            alu_op     <= '0;
            wp         <= '0;
            hist_count <= '0;
            view_idx   <= '0;
            fresh0     <= 1'b1;
            fresh1     <= 1'b1;
        end else if (strobe) begin
            case (act)
                LOAD_OP: alu_op <= in[OP_W-1:0];
                LOAD_A: begin
                    alu_src0 <= chunk(alu_src0, fresh0, in);
                    fresh0   <= 1'b0;
                end
                LOAD_B: begin
                    alu_src1 <= chunk(alu_src1, fresh1, in);
                    fresh1   <= 1'b0;
                end
                EXEC: begin
                    wp       <= wp + VW'(1);
                    view_idx <= '0;
                    fresh0   <= 1'b1;
                    fresh1   <= 1'b1;
                    if (hist_count != CW'(DEPTH)) hist_count <= hist_count + CW'(1);
                end
                OLDER: begin
                    if (hist_count != '0 && (CW'(view_idx) + CW'(1)) < hist_count)
                        view_idx <= view_idx + VW'(1);
                end
                NEWER: begin
                    if (view_idx != '0) view_idx <= view_idx - VW'(1);
                end
                CLEAR: begin
                    alu_src0 <= '0;
                    alu_src1 <= '0;
                    fresh0   <= 1'b1;
                    fresh1   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // History contents need no reset: they are masked while hist_count is zero.
    always_ff @(posedge clk) begin
        if (strobe && act == EXEC) hist[wp] <= alu_res;
    end

    assign rd_idx   = wp - VW'(1) - view_idx;
    assign data_out = (hist_count == '0) ? '0 : hist[rd_idx];

endmodule
